// File: rtl/fir_s2p_buffer_if.sv
// fir_s2p_buffer_if: bus between the FIR output, the serial-to-parallel
// buffer and the FFT input.
//
// Handshake rules:
//   - in_valid is a strobe with no back-pressure. A sample offered while no
//     bank is free is dropped, and overrun reports the drop one cycle later.
//   - A frame transfers on a rising clk edge where out_valid=1 and
//     out_ready=1. While out_valid=1, out_d is held stable. out_valid never
//     depends on out_ready. out_ready with out_valid=0 is ignored.
//
// dbg_bank_state exposes the two bank state machines as {bank1, bank0}.
// Each 2-bit field is 0=EMPTY, 1=FILLING, 2=FULL.
interface fir_s2p_buffer_if #(
    parameter int N  = 16,
    parameter int DW = 16
);
    logic            in_valid;
    logic [DW-1:0]   in_d;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_d;
    logic            overrun;
    logic [3:0]      dbg_bank_state;

    // Buffer side
    modport slave (
        input  in_valid,
        input  in_d,
        input  out_ready,
        output out_valid,
        output out_d,
        output overrun,
        output dbg_bank_state
    );

    // Producer/consumer side (FIR + FFT, or a bench)
    modport master (
        output in_valid,
        output in_d,
        output out_ready,
        input  out_valid,
        input  out_d,
        input  overrun,
        input  dbg_bank_state
    );
endinterface

// File: rtl/fir_s2p_buffer.sv
// fir_s2p_buffer: ping-pong serial-to-parallel stage between FIR and FFT.
// Samples are collected into N-sample frames in two banks. One bank fills
// while the other is offered to the FFT as a single N*DW-bit word.
//
// Optional build macro S2P_BIT_REVERSE_EN:
//   When defined, sample i of a frame is stored in slot bitrev(i). The frame
//   is then delivered in bit-reversed order for an in-place radix-2 DIT FFT.
//   When undefined, slot i holds sample i (natural order).
//   Ports, latency and handshake are the same in both builds.
module fir_s2p_buffer #(
    parameter int N  = 16,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst,
    fir_s2p_buffer_if.slave  bus
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    bank_state_t     bank_st_q [2];
    bank_state_t     bank_st_d [2];
    logic [N*DW-1:0] bank_q    [2];
    logic [N*DW-1:0] bank_d    [2];

    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [LW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            overrun_q, overrun_d;
    logic [N*DW-1:0] out_d_q, out_d_d;

    logic            handshake;
    logic            wr_bank_full;
    logic            accept;
    logic [LW-1:0]   wr_addr;

    // Map the arrival index within a frame to its storage slot.
    function automatic logic [LW-1:0] slot_addr(input logic [LW-1:0] idx);
        logic [LW-1:0] r;
`ifdef S2P_BIT_REVERSE_EN
        for (int b = 0; b < LW; b++) begin
            r[b] = idx[LW-1-b];
        end
`else
        r = idx;
`endif
        return r;
    endfunction

    // Handshake and write-acceptance decode. A bank freed by this cycle's
    // handshake can take the incoming sample in the same cycle.
    always_comb begin
        handshake    = out_valid_q && bus.out_ready;
        wr_bank_full = (bank_st_q[wr_sel_q] == BANK_FULL) &&
                       !(handshake && (rd_sel_q == wr_sel_q));
        accept       = bus.in_valid && !wr_bank_full;
        wr_addr      = slot_addr(wr_cnt_q);
    end

    // Next state: bank FSMs, bank contents, pointers and registered outputs.
    always_comb begin
        bank_st_d[0] = bank_st_q[0];
        bank_st_d[1] = bank_st_q[1];
        bank_d[0]    = bank_q[0];
        bank_d[1]    = bank_q[1];
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        wr_cnt_d     = wr_cnt_q;
        overrun_d    = bus.in_valid && wr_bank_full;

        // The read side releases its bank first, so a write to the same bank
        // later in this block sees it as EMPTY and starts a new frame.
        if (handshake) begin
            bank_st_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d            = ~rd_sel_q;
        end

        if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (wr_addr == LW'(k)) begin
                    bank_d[wr_sel_q][k*DW +: DW] = bus.in_d;
                end
            end
            if (wr_cnt_q == LW'(N-1)) begin
                bank_st_d[wr_sel_q] = BANK_FULL;
                wr_cnt_d            = '0;
                wr_sel_d            = ~wr_sel_q;
            end else begin
                bank_st_d[wr_sel_q] = BANK_FILLING;
                wr_cnt_d            = wr_cnt_q + LW'(1);
            end
        end

        // Present whatever bank the read pointer will point at. The word is
        // only reloaded while a frame is valid, so it holds between frames.
        out_valid_d = (bank_st_d[rd_sel_d] == BANK_FULL);
        out_d_d     = out_valid_d ? bank_d[rd_sel_d] : out_d_q;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            bank_q[0]    <= '0;
            bank_q[1]    <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            wr_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            out_d_q      <= '0;
        end else begin
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
            bank_q[0]    <= bank_d[0];
            bank_q[1]    <= bank_d[1];
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_cnt_q     <= wr_cnt_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            out_d_q      <= out_d_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.out_valid      = out_valid_q;
        bus.out_d          = out_d_q;
        bus.overrun        = overrun_q;
        bus.dbg_bank_state = {bank_st_q[1], bank_st_q[0]};
    end
endmodule
